// File: rtl/wdt_ctrl.sv
// wdt_ctrl: register front-end sequencing watchdog enable, kick stretch and timeout-count handoff
module wdt_ctrl #(
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned KICK_HOLD  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic        err,
   output logic [31:0] rdata,
   input  logic        wto_in,
   output logic        WDEN,
   output logic        WDLIVE,
   output logic [31:0] WTOCNT,
   output logic        irq
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ARMED   = 3'd2,
      S_KICK    = 3'd3,
      S_DISABLE = 3'd4
   } state_t;
   localparam logic [7:0] L_SETTLE = 8'(SETTLE_CYC);
   localparam logic [7:0] L_HOLD   = 8'(KICK_HOLD);
   state_t      r_state, w_nstate;
   logic [7:0]  r_cnt, w_ncnt;
   logic        r_ack, r_err, r_irq, r_irq_en, r_to, r_s1, r_s2, r_s3;
   logic [31:0] r_rdata, r_cnt_reg, w_rdval;
   logic        w_wr, w_wr_ctrl, w_wr_cnt, w_wr_kick, w_w1c, w_dis, w_busy, w_en, w_edge, w_err;
   assign w_wr      = req & we;
   assign w_wr_ctrl = w_wr & (addr == 2'd0);
   assign w_wr_cnt  = w_wr & (addr == 2'd1);
   assign w_wr_kick = w_wr & (addr == 2'd2);
   assign w_w1c     = w_wr & (addr == 2'd3) & wdata[0];
   assign w_dis     = w_wr_ctrl & ~wdata[0];
   assign w_busy    = (r_state == S_LOAD) | (r_state == S_KICK) | (r_state == S_DISABLE);
   assign w_en      = (r_state == S_LOAD) | (r_state == S_ARMED) | (r_state == S_KICK);
   assign w_edge    = r_s2 & ~r_s3;
   assign w_err     = (w_wr_cnt & (r_state != S_IDLE))
                    | (w_wr_kick & ~((r_state == S_ARMED) | (r_state == S_KICK)))
                    | (w_wr_ctrl & wdata[0] & (r_state == S_DISABLE));
   assign w_rdval   = (addr == 2'd0) ? {30'd0, r_irq_en, w_en} :
                      (addr == 2'd1) ? r_cnt_reg :
                      (addr == 2'd3) ? {27'd0, r_state, w_busy, r_to} : 32'd0;
   assign ack    = r_ack;
   assign err    = r_err;
   assign rdata  = r_rdata;
   assign irq    = r_irq;
   assign WTOCNT = r_cnt_reg;
   assign WDEN   = (r_state == S_ARMED) | (r_state == S_KICK);
   assign WDLIVE = (r_state == S_KICK);
   // next state and shared settle/hold counter; counter saturates at zero
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = (r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0;
      case (r_state)
         S_IDLE: begin
            if (w_wr_ctrl && wdata[0]) begin
               w_nstate = S_LOAD;
               w_ncnt   = L_SETTLE;
            end
         end
         S_LOAD: begin
            if (w_dis) begin
               w_nstate = S_DISABLE;
               w_ncnt   = L_SETTLE;
            end else if (r_cnt == 8'd0) w_nstate = S_ARMED;
         end
         S_ARMED: begin
            if (w_dis) begin
               w_nstate = S_DISABLE;
               w_ncnt   = L_SETTLE;
            end else if (w_wr_kick) begin
               w_nstate = S_KICK;
               w_ncnt   = L_HOLD;
            end
         end
         S_KICK: begin
            if (w_dis) begin
               w_nstate = S_DISABLE;
               w_ncnt   = L_SETTLE;
            end else if (r_cnt <= 8'd1) w_nstate = S_ARMED;
         end
         S_DISABLE: begin
            if (r_cnt <= 8'd1) w_nstate = S_IDLE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end
   // state and counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
      end
   end
   // register access response, CNT and IRQ_EN storage
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= 32'd0;
         r_cnt_reg <= 32'd0;
         r_irq_en  <= 1'b0;
      end else begin
         r_ack     <= req;
         r_err     <= w_err;
         r_rdata   <= (req && !we) ? w_rdval : 32'd0;
         r_cnt_reg <= (w_wr_cnt && r_state == S_IDLE) ? wdata : r_cnt_reg;
         r_irq_en  <= w_wr_ctrl ? wdata[1] : r_irq_en;
      end
   end
   // WTO synchronizer, edge detect, sticky flag (set beats clear) and interrupt
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_s3  <= 1'b0;
         r_to  <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         r_s1  <= wto_in;
         r_s2  <= r_s1;
         r_s3  <= r_s2;
         r_to  <= w_edge | (r_to & ~w_w1c);
         r_irq <= r_to & r_irq_en;
      end
   end
endmodule

// File: tb/tb_wdt_ctrl.sv
// tb_wdt_ctrl: directed vector and sequence checks for wdt_ctrl
module tb_wdt_ctrl;
   logic        clk = 1'b0;
   logic        rst, req, we, wto_in;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic        ack, err, WDEN, WDLIVE, irq;
   logic [31:0] rdata, WTOCNT;
   int          n_chk = 0;
   int          n_err = 0;
   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [31:0] exp_cnt;
   } vec_t;
   vec_t tv[11];
   wdt_ctrl #(.SETTLE_CYC(8), .KICK_HOLD(8)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .err(err), .rdata(rdata), .wto_in(wto_in),
      .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT), .irq(irq)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask
   task automatic acc(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic e_err, input logic [31:0] e_rd, input string nm);
      req = 1'b1; we = w; addr = a; wdata = d;
      tick();
      req = 1'b0; we = 1'b0; wdata = 32'd0;
      chk({nm, "_ack"}, {31'd0, ack}, 32'd1);
      chk({nm, "_err"}, {31'd0, err}, {31'd0, e_err});
      chk({nm, "_rdata"}, rdata, e_rd);
   endtask
   initial begin
      tv[0]  = '{1'b0, 2'd0, 32'd0,     1'b0, 32'd0,     32'd0};
      tv[1]  = '{1'b0, 2'd1, 32'd0,     1'b0, 32'd0,     32'd0};
      tv[2]  = '{1'b0, 2'd2, 32'd0,     1'b0, 32'd0,     32'd0};
      tv[3]  = '{1'b0, 2'd3, 32'd0,     1'b0, 32'd0,     32'd0};
      tv[4]  = '{1'b1, 2'd2, 32'd1,     1'b1, 32'd0,     32'd0};
      tv[5]  = '{1'b1, 2'd1, 32'h100,   1'b0, 32'd0,     32'h100};
      tv[6]  = '{1'b0, 2'd1, 32'd0,     1'b0, 32'h100,   32'h100};
      tv[7]  = '{1'b1, 2'd0, 32'd0,     1'b0, 32'd0,     32'h100};
      tv[8]  = '{1'b0, 2'd0, 32'd0,     1'b0, 32'd0,     32'h100};
      tv[9]  = '{1'b1, 2'd3, 32'd1,     1'b0, 32'd0,     32'h100};
      tv[10] = '{1'b0, 2'd3, 32'd0,     1'b0, 32'd0,     32'h100};
      rst = 1'b0; req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0; wto_in = 1'b0;
      tick(); tick();
      chk("rst_wden", {31'd0, WDEN}, 32'd0);
      chk("rst_wdlive", {31'd0, WDLIVE}, 32'd0);
      chk("rst_wtocnt", WTOCNT, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 11; i++) begin
         acc(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].exp_err, tv[i].exp_rd, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_wtocnt", i), WTOCNT, tv[i].exp_cnt);
         chk($sformatf("vec%0d_wden", i), {31'd0, WDEN}, 32'd0);
      end
      tick();
      chk("idle_ack", {31'd0, ack}, 32'd0);
      chk("idle_rdata", rdata, 32'd0);
      acc(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, "en_wr");
      chk("load_wden0", {31'd0, WDEN}, 32'd0);
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd6, "load_status");
      chk("load_wden1", {31'd0, WDEN}, 32'd0);
      acc(1'b0, 2'd0, 32'd0, 1'b0, 32'd1, "load_ctrl");
      chk("load_wden2", {31'd0, WDEN}, 32'd0);
      for (int i = 3; i <= 9; i++) begin
         tick();
         chk($sformatf("load_wden%0d", i), {31'd0, WDEN}, (i == 9) ? 32'd1 : 32'd0);
      end
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd8, "armed_status");
      acc(1'b1, 2'd1, 32'h55, 1'b1, 32'd0, "armed_cnt_wr");
      chk("armed_wtocnt", WTOCNT, 32'h100);
      for (int k = 0; k < 12; k++) begin
         if (k == 0) acc(1'b1, 2'd2, 32'd1, 1'b0, 32'd0, "kick1");
         else if (k == 3) acc(1'b1, 2'd2, 32'd1, 1'b0, 32'd0, "kick2");
         else tick();
         chk($sformatf("kick_wdlive_c%0d", k), {31'd0, WDLIVE}, (k < 8) ? 32'd1 : 32'd0);
         chk($sformatf("kick_wden_c%0d", k), {31'd0, WDEN}, 32'd1);
      end
      acc(1'b1, 2'd2, 32'd1, 1'b0, 32'd0, "kick3");
      chk("kick3_wdlive", {31'd0, WDLIVE}, 32'd1);
      tick();
      acc(1'b1, 2'd0, 32'd0, 1'b0, 32'd0, "dis_wr");
      chk("dis_wdlive", {31'd0, WDLIVE}, 32'd0);
      chk("dis_wden", {31'd0, WDEN}, 32'd0);
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd18, "dis_status");
      acc(1'b1, 2'd0, 32'd1, 1'b1, 32'd0, "dis_en_reject");
      acc(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, "dis_ctrl");
      for (int i = 0; i < 4; i++) tick();
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd18, "dis_status_last");
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd0, "dis_status_idle");
      acc(1'b1, 2'd0, 32'd2, 1'b0, 32'd0, "irqen_wr");
      wto_in = 1'b1;
      tick(); tick(); tick();
      wto_in = 1'b0;
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd1, "to_set");
      chk("to_irq", {31'd0, irq}, 32'd1);
      tick(); tick();
      wto_in = 1'b1;
      tick(); tick();
      acc(1'b1, 2'd3, 32'd1, 1'b0, 32'd0, "w1c_vs_edge");
      wto_in = 1'b0;
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd1, "to_setwins");
      chk("to_irq2", {31'd0, irq}, 32'd1);
      acc(1'b1, 2'd3, 32'd1, 1'b0, 32'd0, "w1c");
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd0, "to_cleared");
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      acc(1'b1, 2'd1, 32'hABCD, 1'b0, 32'd0, "cnt_abcd");
      acc(1'b1, 2'd0, 32'd3, 1'b0, 32'd0, "en_irq_wr");
      wto_in = 1'b1;
      tick(); tick(); tick();
      wto_in = 1'b0;
      tick(); tick();
      chk("mid_load_irq", {31'd0, irq}, 32'd1);
      chk("mid_load_wden", {31'd0, WDEN}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_load_irq", {31'd0, irq}, 32'd0);
      chk("rst_load_wtocnt", WTOCNT, 32'd0);
      chk("rst_load_wden", {31'd0, WDEN}, 32'd0);
      rst = 1'b1;
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd0, "rst_load_status");
      acc(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, "rst_load_ctrl");
      acc(1'b1, 2'd1, 32'h77, 1'b0, 32'd0, "cnt_77");
      acc(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, "en_wr2");
      for (int i = 0; i < 9; i++) tick();
      chk("armed2_wden", {31'd0, WDEN}, 32'd1);
      acc(1'b1, 2'd2, 32'd1, 1'b0, 32'd0, "kick_r");
      chk("kick_r_wdlive", {31'd0, WDLIVE}, 32'd1);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_kick_wden", {31'd0, WDEN}, 32'd0);
      chk("rst_kick_wdlive", {31'd0, WDLIVE}, 32'd0);
      chk("rst_kick_wtocnt", WTOCNT, 32'd0);
      rst = 1'b1;
      acc(1'b0, 2'd3, 32'd0, 1'b0, 32'd0, "rst_kick_status");
      acc(1'b0, 2'd1, 32'd0, 1'b0, 32'd0, "rst_kick_cnt");
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/wdt_ctrl.md
Name: wdt_ctrl

Overview:
- System-clock register front-end that sequences the watchdog timer's control inputs: WDEN, WDLIVE and the quasi-static WTOCNT.
- WTOCNT crosses to the watchdog clock without a handshake, so this block guarantees it is stable for a settle window around every enable and disable edge.
- It also stretches each kick so the slow-clock synchronizer cannot miss it.
- It synchronizes the watchdog's WTO back into clk and raises a sticky status bit and an interrupt.

Parameters:
- SETTLE_CYC, 8: clk cycles WTOCNT is held stable before WDEN rises or after it falls. Must be >= 3 watchdog-clock periods expressed in clk cycles. Legal range 1..255.
- KICK_HOLD, 8: clk cycles WDLIVE is held high per kick. Same constraint and range as SETTLE_CYC.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- req  in  1  register access request, one access per cycle
- we  in  1  1 = write, 0 = read
- addr  in  2  word address: 0 CTRL, 1 CNT, 2 KICK, 3 STATUS
- wdata  in  32  write data
- ack  out  1  access done; pulses exactly 1 cycle after each req cycle
- err  out  1  valid with ack; 1 = access rejected
- rdata  out  32  read data; valid with ack, 0 otherwise
- wto_in  in  1  watchdog WTO, asynchronous to clk
- WDEN  out  1  to watchdog
- WDLIVE  out  1  to watchdog
- WTOCNT  out  32  to watchdog timeout count
- irq  out  1  level interrupt

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, all outputs 0, cnt_reg = 0, to_sticky = 0, irq_en = 0, all counters 0, synchronizer flops 0.
- Reset applied mid-sequence aborts it immediately: WDEN and WDLIVE drop in the same cycle.
- Registers:
  - CTRL: bit0 EN, bit1 IRQ_EN.
  - CNT: 32-bit, drives WTOCNT continuously.
  - KICK: write-only; any write is a kick request.
  - STATUS: bit0 TO (sticky, write-1-to-clear), bit1 BUSY (state is LOAD, KICK or DISABLE), bits[4:2] state encoding, rest 0.
- Register access:
  - ack is registered, 1-cycle latency, with no back-pressure.
  - Reads return the current register value. KICK reads as 0 with err=0.
  - Back-to-back req cycles each produce an ack.
- FSM states: IDLE=0, LOAD=1, ARMED=2, KICK=3, DISABLE=4.
- IDLE:
  - WDEN=0, WDLIVE=0.
  - CNT writes are accepted.
  - Writing CTRL EN=1 loads the settle counter with SETTLE_CYC and goes to LOAD.
- LOAD:
  - Counts down to 0, then goes to ARMED and drives WDEN=1 from the next cycle.
  - Writing EN=0 during LOAD goes to DISABLE.
- ARMED:
  - WDEN=1.
  - A KICK write loads the hold counter with KICK_HOLD and goes to KICK.
  - Writing EN=0 goes to DISABLE.
  - Writing EN=1 again is a no-op.
- KICK:
  - WDEN=1, WDLIVE=1 for exactly KICK_HOLD cycles, then back to ARMED.
  - A further KICK write during KICK is coalesced: ignored, err=0, hold counter not restarted.
  - Writing EN=0 during KICK drops WDLIVE immediately and goes to DISABLE.
- DISABLE:
  - WDEN=0, WDLIVE=0.
  - Holds for SETTLE_CYC cycles, then goes to IDLE.
  - Writing EN=1 during DISABLE returns err=1 and is ignored.
- Rejected accesses (err=1, no state change):
  - CNT write in any state other than IDLE.
  - KICK write in IDLE, LOAD or DISABLE.
- CTRL.EN readback is 1 in LOAD, ARMED and KICK; 0 otherwise. IRQ_EN writes are always accepted.
- Timeout path:
  - wto_in goes through a 2-flop synchronizer, then a rising-edge detect.
  - An edge sets TO.
  - irq = TO & IRQ_EN, registered.
  - A W1C write and a new edge in the same cycle leave TO=1 (set wins).
  - TO does not change FSM state.
- Counters are 8-bit and never wrap: they load, decrement to 0, then stop.

Test Plan:
- Reset, then read all registers -> rdata 0 for every address. WDEN=0, WDLIVE=0, WTOCNT=0, irq=0, ack exactly 1 cycle after each req.
- Write CNT=0x0000_0100, then CTRL=1, with SETTLE_CYC=8 -> WTOCNT=0x100 from the cycle after the write. WDEN rises 9 cycles after the CTRL ack. STATUS.BUSY=1 during LOAD.
- In ARMED, write KICK, then KICK again 3 cycles later -> WDLIVE high exactly 8 cycles, single pulse, second write err=0. Write CNT while ARMED -> err=1 and WTOCNT unchanged.
- In KICK, write CTRL=0 -> WDLIVE and WDEN low the next cycle. BUSY stays 1 for 8 cycles, then state reads IDLE. A CTRL=1 write during that window -> err=1.
- With IRQ_EN=1, pulse wto_in high for 3 clk -> TO=1 within 3 cycles, irq=1. Write STATUS=1 on the cycle a second wto_in edge is detected -> TO stays 1. A later W1C clears TO and irq.
- Drive rst low mid-LOAD and mid-KICK -> all outputs 0 on the next edge, state IDLE, CNT=0.
